// File: rtl/varredura_teclado_pkg.sv
// Shared definitions for the keypad scanner: key codes, keymap and timing defaults.
// Timing defaults assume a 4 MHz clock: 1 ms per scan frame, 20 frames (~20 ms) to debounce.
// No logic here; the keymap lookup is a pure function.
package varredura_teclado_pkg;

  localparam int CLK_FREQ            = 4_000_000;
  localparam int FRAME_HZ            = 1000;
  localparam int DEBOUNCE_MS         = 20;
  localparam int SCAN_DIV_DFLT       = CLK_FREQ / (4 * FRAME_HZ);
  localparam int DEBOUNCE_SCANS_DFLT = DEBOUNCE_MS * FRAME_HZ / 1000;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_t;

  // Row r / column c of the 4x4 keypad to its 4-bit key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = KEY_STAR;
      4'hD:    k = 4'h0;
      4'hE:    k = KEY_HASH;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/varredura_teclado_sync_2ff.sv
// Two-flop synchroniser for asynchronous multi-bit level inputs (keypad rows).
// Latency: 2 clk cycles. No backpressure; outputs clear to zero under reset.
// Bits are synchronised independently; only suitable for slow, debounced levels.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/varredura_teclado.sv
// 4x4 keypad scanner: drives columns, debounces whole-scan frames, emits one event per press.
// Latency: key_valid one cycle after the accepting frame end; worst case (DB+1)*4*SCAN_DIV+3.
// No backpressure: key_valid is a single-cycle pulse, key_code holds until the next event.
module varredura_teclado
  import varredura_teclado_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DFLT,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);

  logic [DIV_W-1:0] div;
  logic [1:0]       col_sel;
  logic [3:0]       row_s;
  logic             sample;
  logic             frame_end;
  logic [2:0]       n_low;
  logic [1:0]       row_idx;
  logic [1:0]       acc_cnt;
  logic [3:0]       acc_code;
  logic [1:0]       frame_cnt;
  logic [3:0]       frame_code;
  state_t           state, state_n;
  logic [DB_W-1:0]  db, db_n, db_inc;
  logic [3:0]       cand, cand_n;
  logic [3:0]       code_n;
  logic             valid_n;

  sync_2ff #(.W(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  // Rows are sampled at the last cycle of each column slot, giving the lines time to settle.
  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (col_sel == 2'd3);
  assign col_out   = ~(4'b0001 << col_sel);
  assign key_held  = (state == S_HELD) || (state == S_REL_DB);

  // Column slot timer and column selector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      col_sel <= 2'd0;
    end else if (sample) begin
      div     <= '0;
      col_sel <= col_sel + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Count low rows in the current sample and remember which one.
  always_comb begin
    n_low   = 3'd0;
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_s[i]) begin
        n_low   = n_low + 3'd1;
        row_idx = 2'(i);
      end
    end
  end

  // Fold this sample into the frame totals; a multi-row sample counts as a chord.
  always_comb begin
    frame_cnt  = acc_cnt;
    frame_code = acc_code;
    if (n_low == 3'd1) begin
      frame_cnt  = (acc_cnt == 2'd0) ? 2'd1 : 2'd2;
      frame_code = key_map(row_idx, col_sel);
    end else if (n_low >= 3'd2) begin
      frame_cnt = 2'd2;
    end
  end

  // Per-frame accumulators, cleared when the frame result is handed to the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (frame_end) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      acc_cnt  <= frame_cnt;
      acc_code <= frame_code;
    end
  end

  assign db_inc = (db == DB_TARGET) ? db : db + 1'b1;

  // Debounce FSM next state, advanced only at frame ends.
  always_comb begin
    state_n = state;
    db_n    = db;
    cand_n  = cand;
    code_n  = key_code;
    valid_n = 1'b0;
    if (frame_end) begin
      unique case (state)
        S_IDLE: begin
          if (frame_cnt == 2'd1) begin
            cand_n  = frame_code;
            db_n    = DB_ONE;
            state_n = S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (frame_cnt == 2'd1 && frame_code == cand) begin
            if (db_inc == DB_TARGET) begin
              code_n  = cand;
              valid_n = 1'b1;
              db_n    = '0;
              state_n = S_HELD;
            end else begin
              db_n = db_inc;
            end
          end else begin
            db_n    = '0;
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (frame_cnt == 2'd0) begin
            db_n    = DB_ONE;
            state_n = S_REL_DB;
          end
        end
        S_REL_DB: begin
          if (frame_cnt == 2'd0) begin
            if (db_inc == DB_TARGET) begin
              db_n    = '0;
              state_n = S_IDLE;
            end else begin
              db_n = db_inc;
            end
          end else begin
            db_n    = '0;
            state_n = S_HELD;
          end
        end
        default: begin
          db_n    = '0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      db        <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      db        <= db_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_varredura_teclado.sv
// Bench for varredura_teclado with SCAN_DIV=8, DEBOUNCE_SCANS=3 (32-cycle frames).
// A keypad model pulls rows low for pressed keys on the driven column; a frame-level
// reference model predicts key_valid/key_code/key_held every cycle.
module tb_varredura_teclado;

  localparam int S     = 8;
  localparam int D     = 3;
  localparam int FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] pressed = 16'h0;  // bit r*4+c

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          kcnt = 0;
  logic [15:0] p1 = 16'h0, p2 = 16'h0;
  int          f_cnt = 0;
  logic [3:0]  f_code = 4'h0;
  int          m_run = 0, m_rel = 0, m_events = 0;
  logic        m_held = 1'b0;
  logic [3:0]  m_cand = 4'h0;
  logic        exp_valid = 1'b0, exp_held = 1'b0;
  logic [3:0]  exp_code = 4'h0;

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  varredura_teclado #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Reference model: frame results from the keys seen two cycles before each sample.
  always @(posedge clk) begin
    int col, n, rr;
    if (!rst) begin
      kcnt = 0; f_cnt = 0; f_code = 4'h0; m_run = 0; m_rel = 0;
      m_held = 1'b0; m_cand = 4'h0; exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'h0;
    end else begin
      exp_valid = 1'b0;
      if (kcnt % S == S - 1) begin
        col = (kcnt / S) % 4;
        n = 0; rr = 0;
        for (int r = 0; r < 4; r++) if (p2[r*4+col]) begin n++; rr = r; end
        if (n == 1) begin
          f_cnt  = (f_cnt >= 1) ? 2 : 1;
          f_code = keymap[rr*4+col];
        end else if (n >= 2) begin
          f_cnt = 2;
        end
        if (col == 3) begin
          if (!m_held) begin
            if (m_run > 0) begin
              if (f_cnt == 1 && f_code == m_cand) begin
                m_run++;
                if (m_run == D) begin
                  exp_valid = 1'b1; exp_code = m_cand; m_held = 1'b1; m_run = 0; m_events++;
                end
              end else begin
                m_run = 0;
              end
            end else if (f_cnt == 1) begin
              m_cand = f_code; m_run = 1;
            end
          end else begin
            if (f_cnt == 0) begin
              m_rel++;
              if (m_rel == D) begin m_held = 1'b0; m_rel = 0; end
            end else begin
              m_rel = 0;
            end
          end
          exp_held = m_held;
          f_cnt = 0;
        end
      end
      kcnt++;
    end
    p2 = p1;
    p1 = pressed;
  end

  // Cycle-by-cycle comparison against the model (or the reset values while in reset).
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (key_valid !== exp_valid) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL cyc_key_valid t=%0t: got %0b want %0b", $time, key_valid, exp_valid);
      end
      n_cmp++;
      if (key_held !== exp_held) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL cyc_key_held t=%0t: got %0b want %0b", $time, key_held, exp_held);
      end
      n_cmp++;
      if (key_code !== exp_code) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL cyc_key_code t=%0t: got %h want %h", $time, key_code, exp_code);
      end
    end else begin
      n_cmp++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0 || col_out !== 4'b1110) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL cyc_in_reset t=%0t: got v=%0b h=%0b code=%h col=%b want 0 0 0 1110",
                                  $time, key_valid, key_held, key_code, col_out);
      end
    end
  end

  task automatic wait_cycles(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] cols [4];
    cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    pressed = 16'h0;
    repeat (45) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (col_out !== 4'b1110) begin n_bad++; $display("FAIL reset_col_out: got %b want 1110", col_out); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %0b want 0", key_valid); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_key_code: got %h want 0", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_key_held: got %0b want 0", key_held); end
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) @(posedge clk);
      else repeat (S) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (col_out !== cols[i]) begin
        n_bad++; $display("FAIL scan_col%0d: got %b want %b", i, col_out, cols[i]);
      end
    end
  endtask

  task automatic test_press5();
    int pulses, first, fall, p;
    pulses = 0; first = -1; fall = -1;
    @(negedge clk);
    pressed = 16'h0; pressed[5] = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (key_valid) begin pulses++; if (first < 0) first = t; end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL press5_pulses: got %0d want 1", pulses); end
    n_cmp++; if (key_code !== 4'h5) begin n_bad++; $display("FAIL press5_code: got %h want 5", key_code); end
    n_cmp++; if (!(first >= 1 && first <= 131)) begin n_bad++; $display("FAIL press5_latency: got %0d want 1..131", first); end
    n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL press5_held: got %0b want 1", key_held); end
    pressed = 16'h0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (!key_held && fall < 0) fall = t;
    end
    n_cmp++; if (!(fall >= 64 && fall <= 140)) begin n_bad++; $display("FAIL press5_release: got %0d want 64..140", fall); end
    wait_cycles(50, p);
  endtask

  task automatic test_bounce7();
    int p1c, p2c;
    logic [3:0] saved;
    saved = exp_code;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (kcnt % FRAME == FRAME - 1) break;
      @(negedge clk);
    end
    p1c = 0;
    for (int i = 0; i < 10; i++) begin
      pressed[8] = (i % 2 == 0);
      wait_cycles(20, p2c);
      p1c += p2c;
    end
    pressed = 16'h0;
    wait_cycles(150, p2c);
    p1c += p2c;
    n_cmp++; if (p1c !== 0) begin n_bad++; $display("FAIL bounce7_pulses: got %0d want 0", p1c); end
    n_cmp++; if (key_code !== saved) begin n_bad++; $display("FAIL bounce7_code: got %h want %h", key_code, saved); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL bounce7_held: got %0b want 0", key_held); end
  endtask

  task automatic test_star_hash();
    int p, prel;
    @(negedge clk);
    pressed = 16'h0; pressed[12] = 1'b1;
    wait_cycles(2000, p);
    n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL star_pulses: got %0d want 1", p); end
    n_cmp++; if (key_code !== 4'hE) begin n_bad++; $display("FAIL star_code: got %h want e", key_code); end
    pressed = 16'h0;
    wait_cycles(150, prel);
    pressed[14] = 1'b1;
    wait_cycles(200, p);
    n_cmp++; if (p + prel !== 1) begin n_bad++; $display("FAIL hash_pulses: got %0d want 1", p + prel); end
    n_cmp++; if (key_code !== 4'hF) begin n_bad++; $display("FAIL hash_code: got %h want f", key_code); end
    pressed = 16'h0;
    wait_cycles(200, p);
  endtask

  task automatic test_chord();
    int p;
    @(negedge clk);
    pressed = 16'h0; pressed[0] = 1'b1; pressed[1] = 1'b1;
    wait_cycles(200, p);
    n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL chord_pulses: got %0d want 0", p); end
    pressed[1] = 1'b0;
    wait_cycles(200, p);
    n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL chord_single_pulses: got %0d want 1", p); end
    n_cmp++; if (key_code !== 4'h1) begin n_bad++; $display("FAIL chord_single_code: got %h want 1", key_code); end
    pressed = 16'h0;
    wait_cycles(200, p);
  endtask

  task automatic test_reset_mid();
    int p, first, pulses;
    @(negedge clk);
    pressed = 16'h0; pressed[10] = 1'b1;
    wait_cycles(50, p);
    n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL rstmid_early_pulses: got %0d want 0", p); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL rstmid_early_held: got %0b want 0", key_held); end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    first = -1; pulses = 0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (key_valid) begin pulses++; if (first < 0) first = t; end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 1", pulses); end
    n_cmp++; if (key_code !== 4'h9) begin n_bad++; $display("FAIL rstmid_code: got %h want 9", key_code); end
    n_cmp++; if (first !== D * FRAME) begin n_bad++; $display("FAIL rstmid_latency: got %0d want %0d", first, D * FRAME); end
    pressed = 16'h0;
    wait_cycles(200, p);
  endtask

  task automatic test_random();
    int ev0, pulses, p;
    ev0 = m_events;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      pressed = 16'h0;
      pressed[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      wait_cycles($urandom_range(20, 250), p);
      pulses += p;
      pressed = 16'h0;
      wait_cycles($urandom_range(20, 250), p);
      pulses += p;
    end
    wait_cycles(200, p);
    pulses += p;
    n_cmp++;
    if (pulses !== m_events - ev0) begin
      n_bad++; $display("FAIL random_pulses: got %0d want %0d", pulses, m_events - ev0);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    test_reset();
    test_press5();
    test_bounce7();
    test_star_hash();
    test_chord();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
